// File: rtl/sr_flag_arbiter_pkg.sv
// Shared types and the SR collision rule for the flag-bank arbiter.
package sr_flag_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_CLR = 2'b01,
    OP_SET = 2'b10,
    OP_TOG = 2'b11
  } op_t;

  // Next value of an SR cell; a simultaneous S and R resolves by clr_wins so it never goes X.
  function automatic logic resolve_sr(input logic s, input logic r, input logic cur,
                                      input logic clr_wins);
    case ({s, r})
      2'b10:   return 1'b1;
      2'b01:   return 1'b0;
      2'b11:   return ~clr_wins;
      default: return cur;
    endcase
  endfunction

endpackage

// File: rtl/sr_flag_arbiter_cell.sv
// One event flag: a 1-bit SR register with synchronous active-low reset.
module sr_flag_cell
  import sr_flag_pkg::*;
#(
  parameter bit CLR_WINS = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_i,
  input  logic r_i,
  output logic q_o
);

  logic q_q, q_d;

  always_comb q_d = resolve_sr(s_i, r_i, q_q, CLR_WINS);

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin shared write port onto a bank of SR event flags, merged with
// per-flag hardware set/clear strobes through a one-stage apply register.
module sr_flag_arbiter
  import sr_flag_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int NFLAG    = 8,
  parameter int IDXW     = $clog2(NFLAG),
  parameter int CLR_WINS = 1,
  localparam int GW      = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [IDXW*NREQ-1:0] req_idx,
  input  logic [NFLAG-1:0]     hw_set,
  input  logic [NFLAG-1:0]     hw_clr,
  output logic [NFLAG-1:0]     flags,
  output logic [NFLAG-1:0]     flags_n,
  output logic                 grant_valid,
  output logic [GW-1:0]        grant_id,
  output logic                 err_range
);

  logic [GW-1:0]   ptr_q, ptr_d;
  logic            cmd_valid_q;
  op_t             cmd_op_q;
  logic [IDXW-1:0] cmd_idx_q;
  logic [GW-1:0]   cmd_id_q;
  logic            err_q;

  op_t             req_op_a  [NREQ];
  logic [IDXW-1:0] req_idx_a [NREQ];
  logic            gnt_found, hs;
  logic [GW-1:0]   gnt_id, cand;

  logic [NFLAG-1:0] flags_q, hit_v, set_v, clr_v;

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    assign req_op_a[g]  = op_t'(req_op[2*g +: 2]);
    assign req_idx_a[g] = req_idx[IDXW*g +: IDXW];
  end

  // Walk upward from the pointer, wrapping at NREQ; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = ptr_q;
    for (int unsigned o = 0; o < NREQ; o++) begin
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
      cand = (cand == GW'(NREQ-1)) ? '0 : cand + 1'b1;
    end
  end

  assign hs    = rst_n & gnt_found;
  assign ptr_d = (gnt_id == GW'(NREQ-1)) ? '0 : gnt_id + 1'b1;

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_NOP;
      cmd_idx_q   <= '0;
      cmd_id_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q       <= cmd_valid_q && (32'(cmd_idx_q) >= NFLAG);
      cmd_valid_q <= hs;
      if (hs) begin
        ptr_q     <= ptr_d;
        cmd_op_q  <= req_op_a[gnt_id];
        cmd_idx_q <= req_idx_a[gnt_id];
        cmd_id_q  <= gnt_id;
      end
    end
  end

  // TOGGLE turns into S or R from the registered flag value.
  for (genvar k = 0; k < NFLAG; k++) begin : g_flag
    assign hit_v[k] = cmd_valid_q && (cmd_idx_q == IDXW'(k));
    assign set_v[k] = hw_set[k] | (hit_v[k] & ((cmd_op_q == OP_SET) |
                                               ((cmd_op_q == OP_TOG) & ~flags_q[k])));
    assign clr_v[k] = hw_clr[k] | (hit_v[k] & ((cmd_op_q == OP_CLR) |
                                               ((cmd_op_q == OP_TOG) &  flags_q[k])));
    sr_flag_cell #(.CLR_WINS(CLR_WINS != 0)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .s_i   (set_v[k]),
      .r_i   (clr_v[k]),
      .q_o   (flags_q[k])
    );
  end

  assign flags       = flags_q;
  assign flags_n     = ~flags_q;
  assign grant_valid = cmd_valid_q;
  assign grant_id    = cmd_id_q;
  assign err_range   = err_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Three instances (clear-wins, set-wins, 6-flag) share stimulus and are checked against a behavioural model.
module tb_sr_flag_arbiter;
  import sr_flag_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [7:0]  req_op = '0;
  logic [11:0] req_idx = '0;
  logic [7:0]  hw_set = '0, hw_clr = '0;

  logic [3:0] rdy_a [3];
  logic [7:0] fl_a  [3];
  logic [7:0] fln_a [3];
  logic       gv_a  [3];
  logic [1:0] gid_a [3];
  logic       err_a [3];
  logic [5:0] fl6, fln6;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .CLR_WINS(1)) dut_cw (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_a[0]),
    .req_op(req_op), .req_idx(req_idx), .hw_set(hw_set), .hw_clr(hw_clr),
    .flags(fl_a[0]), .flags_n(fln_a[0]), .grant_valid(gv_a[0]),
    .grant_id(gid_a[0]), .err_range(err_a[0]));

  sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .CLR_WINS(0)) dut_sw (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_a[1]),
    .req_op(req_op), .req_idx(req_idx), .hw_set(hw_set), .hw_clr(hw_clr),
    .flags(fl_a[1]), .flags_n(fln_a[1]), .grant_valid(gv_a[1]),
    .grant_id(gid_a[1]), .err_range(err_a[1]));

  sr_flag_arbiter #(.NREQ(4), .NFLAG(6), .CLR_WINS(1)) dut_n6 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_a[2]),
    .req_op(req_op), .req_idx(req_idx), .hw_set(hw_set[5:0]), .hw_clr(hw_clr[5:0]),
    .flags(fl6), .flags_n(fln6), .grant_valid(gv_a[2]),
    .grant_id(gid_a[2]), .err_range(err_a[2]));

  assign fl_a[2]  = {2'b00, fl6};
  assign fln_a[2] = {2'b11, fln6};

  // Reference model: pointer, one pending command, flag values, error pulse.
  int       NF [3] = '{8, 8, 6};
  bit       CW [3] = '{1'b1, 1'b0, 1'b1};
  int       mptr [3];
  bit       pv   [3];
  bit [1:0] pop  [3];
  int       pidx [3];
  int       pid  [3];
  bit [7:0] mfl  [3];
  bit       merr [3];

  function automatic int winner(input int ptr);
    for (int o = 0; o < 4; o++) begin
      int c;
      c = (ptr + o) % 4;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(input int m);
    int w;
    w = winner(mptr[m]);
    if (!rst_n || w < 0) return 4'b0000;
    return 4'(1 << w);
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 3; m++) begin
      if (!rst_n) begin
        mptr[m] = 0; pv[m] = 0; pop[m] = 0; pidx[m] = 0; pid[m] = 0; mfl[m] = 0; merr[m] = 0;
      end else begin
        bit [7:0] nf;
        int w;
        nf = mfl[m];
        for (int k = 0; k < NF[m]; k++) begin
          bit s, r;
          s = hw_set[k];
          r = hw_clr[k];
          if (pv[m] && pidx[m] == k) begin
            case (pop[m])
              2'b10: s = 1;
              2'b01: r = 1;
              2'b11: if (mfl[m][k]) r = 1; else s = 1;
              default: ;
            endcase
          end
          if (s && r) nf[k] = !CW[m];
          else if (s) nf[k] = 1;
          else if (r) nf[k] = 0;
        end
        merr[m] = pv[m] && (pidx[m] >= NF[m]);
        mfl[m]  = nf;
        w = winner(mptr[m]);
        pv[m] = (w >= 0);
        if (w >= 0) begin
          pop[m]  = req_op[2*w +: 2];
          pidx[m] = int'(req_idx[3*w +: 3]);
          pid[m]  = w;
          mptr[m] = (w + 1) % 4;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 0; req_valid = '0; hw_set = '0; hw_clr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    req_valid = 4'b1111;
    req_op = {OP_SET, OP_SET, OP_SET, OP_SET};
    req_idx = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++;
      if (rdy_a[0] !== 4'b0000) begin
        tests_failed++; $display("FAIL reset_ready cyc %0d: got %b expected 0000", c, rdy_a[0]);
      end
      @(negedge clk);
      for (int m = 0; m < 3; m++) begin
        tests_run++;
        if (fl_a[m] !== 8'h00 || gv_a[m] !== 1'b0 || err_a[m] !== 1'b0) begin
          tests_failed++;
          $display("FAIL reset_state[%0d]: got flags=%h gv=%b err=%b expected 00/0/0", m, fl_a[m], gv_a[m], err_a[m]);
        end
      end
    end
    rst_n = 1;
    #1;
    for (int m = 0; m < 3; m++) begin
      tests_run++;
      if (rdy_a[m] !== 4'b0001) begin
        tests_failed++; $display("FAIL reset_first_grant[%0d]: got %b expected 0001", m, rdy_a[m]);
      end
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 4'b1111;
    req_op = {OP_SET, OP_SET, OP_SET, OP_SET};
    req_idx = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int c = 0; c < 4; c++) begin
      #1;
      tests_run++;
      if (rdy_a[0] !== 4'(1 << c)) begin
        tests_failed++; $display("FAIL rr_grant cyc %0d: got %b expected %b", c, rdy_a[0], 4'(1 << c));
      end
      @(negedge clk);
      tests_run++;
      if (gv_a[0] !== 1'b1 || gid_a[0] !== 2'(c)) begin
        tests_failed++; $display("FAIL rr_grant_id cyc %0d: got gv=%b id=%0d expected 1/%0d", c, gv_a[0], gid_a[0], c);
      end
    end
    req_valid = '0;
    @(negedge clk);
    for (int m = 0; m < 3; m++) begin
      tests_run++;
      if (fl_a[m] !== 8'h0F) begin
        tests_failed++; $display("FAIL rr_flags[%0d]: got %h expected 0f", m, fl_a[m]);
      end
    end
  endtask

  task automatic test_collision();
    do_reset();
    req_valid = 4'b0001; req_op = {6'b0, OP_SET}; req_idx = 12'd5;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    for (int m = 0; m < 3; m++) begin
      tests_run++;
      if (fl_a[m][5] !== 1'b1) begin
        tests_failed++; $display("FAIL coll_preset[%0d]: got %b expected 1", m, fl_a[m][5]);
      end
    end
    req_valid = 4'b0001; req_op = {6'b0, OP_CLR}; req_idx = 12'd5;
    @(negedge clk);
    req_valid = '0;
    hw_set = 8'h20;
    @(negedge clk);
    hw_set = '0;
    tests_run++;
    if (fl_a[0][5] !== 1'b0) begin
      tests_failed++; $display("FAIL coll_clr_wins: got %b expected 0", fl_a[0][5]);
    end
    tests_run++;
    if (fl_a[1][5] !== 1'b1) begin
      tests_failed++; $display("FAIL coll_set_wins: got %b expected 1", fl_a[1][5]);
    end
    tests_run++;
    if (fl_a[2][5] !== 1'b0) begin
      tests_failed++; $display("FAIL coll_n6: got %b expected 0", fl_a[2][5]);
    end
  endtask

  task automatic test_toggle_chain();
    bit exp_f [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    req_op = {4'b0, OP_TOG, 2'b00};
    req_idx = {6'b0, 3'd2, 3'd0};
    for (int c = 0; c < 5; c++) begin
      req_valid = (c < 3) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      tests_run++;
      if (fl_a[0][2] !== exp_f[c]) begin
        tests_failed++; $display("FAIL toggle_chain cyc %0d: got %b expected %b", c, fl_a[0][2], exp_f[c]);
      end
    end
  endtask

  task automatic test_range_error();
    do_reset();
    req_valid = 4'b0100; req_op = {2'b00, OP_SET, 4'b0}; req_idx = {3'd0, 3'd7, 6'd0};
    @(negedge clk);
    req_valid = '0;
    tests_run++;
    if (err_a[2] !== 1'b0) begin
      tests_failed++; $display("FAIL range_early: got %b expected 0", err_a[2]);
    end
    @(negedge clk);
    tests_run++;
    if (err_a[2] !== 1'b1 || fl_a[2] !== 8'h00) begin
      tests_failed++; $display("FAIL range_pulse: got err=%b flags=%h expected 1/00", err_a[2], fl_a[2]);
    end
    tests_run++;
    if (err_a[0] !== 1'b0 || fl_a[0] !== 8'h80) begin
      tests_failed++; $display("FAIL range_n8: got err=%b flags=%h expected 0/80", err_a[0], fl_a[0]);
    end
    req_valid = 4'b1000; req_op = {OP_SET, 6'b0}; req_idx = {3'd1, 9'd0};
    #1;
    tests_run++;
    if (rdy_a[2] !== 4'b1000) begin
      tests_failed++; $display("FAIL range_next_grant: got %b expected 1000", rdy_a[2]);
    end
    @(negedge clk);
    req_valid = '0;
    tests_run++;
    if (err_a[2] !== 1'b0) begin
      tests_failed++; $display("FAIL range_pulse_end: got %b expected 0", err_a[2]);
    end
    @(negedge clk);
    tests_run++;
    if (fl_a[2] !== 8'h02) begin
      tests_failed++; $display("FAIL range_next_apply: got %h expected 02", fl_a[2]);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    req_valid = 4'b0001; req_op = {6'b0, OP_SET}; req_idx = 12'd4;
    @(negedge clk);
    tests_run++;
    if (gv_a[0] !== 1'b1) begin
      tests_failed++; $display("FAIL midop_accept: got gv=%b expected 1", gv_a[0]);
    end
    rst_n = 0; req_valid = '0;
    @(negedge clk);
    tests_run++;
    if (gv_a[0] !== 1'b0 || fl_a[0][4] !== 1'b0) begin
      tests_failed++; $display("FAIL midop_reset: got gv=%b f4=%b expected 0/0", gv_a[0], fl_a[0][4]);
    end
    rst_n = 1;
    @(negedge clk);
    tests_run++;
    if (fl_a[0][4] !== 1'b0) begin
      tests_failed++; $display("FAIL midop_lost: got f4=%b expected 0", fl_a[0][4]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      req_valid = 4'($urandom);
      req_op    = 8'($urandom);
      req_idx   = 12'($urandom);
      hw_set    = 8'($urandom & $urandom & $urandom);
      hw_clr    = 8'($urandom & $urandom & $urandom);
      #1;
      for (int m = 0; m < 3; m++) begin
        tests_run++;
        if (rdy_a[m] !== exp_ready(m)) begin
          tests_failed++; $display("FAIL rand_ready[%0d] cyc %0d: got %b expected %b", m, c, rdy_a[m], exp_ready(m));
        end
      end
      @(negedge clk);
      for (int m = 0; m < 3; m++) begin
        tests_run++;
        if (fl_a[m] !== 8'(mfl[m]) || fln_a[m] !== 8'(~mfl[m])) begin
          tests_failed++; $display("FAIL rand_flags[%0d] cyc %0d: got %h/%h expected %h/%h", m, c, fl_a[m], fln_a[m], mfl[m], ~mfl[m]);
        end
        tests_run++;
        if (gv_a[m] !== pv[m] || err_a[m] !== merr[m] || (pv[m] && gid_a[m] !== 2'(pid[m]))) begin
          tests_failed++;
          $display("FAIL rand_stage[%0d] cyc %0d: got gv=%b id=%0d err=%b expected %b/%0d/%b", m, c, gv_a[m], gid_a[m], err_a[m], pv[m], pid[m], merr[m]);
        end
      end
    end
    rst_n = 1; req_valid = '0; hw_set = '0; hw_clr = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_collision();
    test_toggle_chain();
    test_range_error();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
